// File: rtl/i_seq_monitor.sv
// i_seq_monitor: passive checker for the inc/dec count buses of i_counter_top.
// Follows the loop inc 0..INC_MAX, dec DEC_START..0, back to 0/0, counts completed
// loops and latches a sticky error code on the first illegal transition.
// Optional stall detection is built only when SEQ_MON_STALL_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset, waiting for inc==0 && dec==0
// S_RISE | inc climbing toward INC_MAX, dec held at 0
// S_FALL | inc parked at INC_MAX, dec falling from DEC_START to 0
// S_ERR  | illegal transition seen; absorbing until RST
module i_seq_monitor #(
  parameter int W         = 8,
  parameter int INC_MAX   = 6,
  parameter int DEC_START = 3,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [W-1:0]     inc,
  input  logic [W-1:0]     dec,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] cycles,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [W-1:0] INC_MAX_V   = W'(INC_MAX);
  localparam logic [W-1:0] DEC_START_V = W'(DEC_START);

  state_t           state_q, state_d;
  logic [W-1:0]     pinc_q, pdec_q;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic inc_chg, dec_chg, unchanged, active;
  logic rise_step, rise_to_fall, fall_step, fall_done;
  logic stall_hit;

  assign inc_chg   = (inc != pinc_q);
  assign dec_chg   = (dec != pdec_q);
  assign unchanged = !inc_chg && !dec_chg;
  assign active    = (state_q == S_RISE) || (state_q == S_FALL);

  // pdec is always 0 while rising, so dec==0 here also means dec did not move
  assign rise_step    = (inc == pinc_q + W'(1)) && (pinc_q < INC_MAX_V) && (dec == '0);
  assign rise_to_fall = (pinc_q == INC_MAX_V) && (inc == INC_MAX_V) &&
                        (pdec_q == '0) && (dec == DEC_START_V);
  assign fall_step    = (pdec_q != '0) && (dec == pdec_q - W'(1)) && (inc == INC_MAX_V);
  assign fall_done    = (pinc_q == INC_MAX_V) && (pdec_q == '0) &&
                        (inc == '0) && (dec == '0);

`ifdef SEQ_MON_STALL_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q, stall_d;

  // the TIMEOUT-th enabled tick without movement is the one that trips
  assign stall_hit = active && unchanged && CE && (stall_q == SW'(TIMEOUT - 1));

  // stall timer register
  always_ff @(posedge CLK) begin
    if (RST) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_ce;

  assign unused_ce = CE;
  assign stall_hit = 1'b0;
`endif

  // state, history and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pinc_q     <= '0;
      pdec_q     <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      pinc_q     <= inc;
      pdec_q     <= dec;
      cycles_q   <= cycles_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // next-state decision from the current sample against the previous one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if ((inc == '0) && (dec == '0)) state_d = S_RISE;
      end
      S_RISE: begin
        if (unchanged) begin
          if (stall_hit) state_d = S_ERR;
        end else if (rise_step) begin
          state_d = S_RISE;
        end else if (rise_to_fall) begin
          state_d = S_FALL;
        end else begin
          state_d = S_ERR;
        end
      end
      S_FALL: begin
        if (unchanged) begin
          if (stall_hit) state_d = S_ERR;
        end else if (fall_step) begin
          state_d = S_FALL;
        end else if (fall_done) begin
          state_d = S_RISE;
        end else begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // loop counter, done pulse, error latch and stall timer next values
  always_comb begin
    cycles_d   = cycles_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    if (active && (state_d == S_ERR)) begin
      err_d = 1'b1;
      // a stall can only trip on an unchanged sample, so step errors win by construction
      if (!unchanged) err_code_d = inc_chg ? 2'd1 : 2'd2;
      else            err_code_d = 2'd3;
    end
    if ((state_q == S_FALL) && (state_d == S_RISE)) begin
      done_d   = 1'b1;
      cycles_d = cycles_q + CNT_W'(1);
    end
`ifdef SEQ_MON_STALL_EN
    stall_d = '0;
    if (active && unchanged && (state_d != S_ERR))
      stall_d = CE ? stall_q + SW'(1) : stall_q;
`endif
  end

  assign phase    = state_q;
  assign cycles   = cycles_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_i_seq_monitor.sv
// Self-checking bench for i_seq_monitor: constant vector table, hand-written
// multi-cycle sequences and a randomized walk checked against a successor-set model.
module tb_i_seq_monitor;

  localparam int W         = 8;
  localparam int INC_MAX   = 6;
  localparam int DEC_START = 3;
  localparam int TMO       = 8;
  localparam int L         = INC_MAX + 1 + DEC_START + 1;

  logic          CLK = 1'b0;
  logic          RST, CE;
  logic [W-1:0]  inc, dec;
  logic [1:0]    phase, phase4, err_code, err_code4;
  logic [15:0]   cycles;
  logic [3:0]    cycles4;
  logic          done, done4, err, err4;

  i_seq_monitor #(.W(W), .INC_MAX(INC_MAX), .DEC_START(DEC_START), .CNT_W(16), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .inc(inc), .dec(dec), .phase(phase),
    .cycles(cycles), .done(done), .err(err), .err_code(err_code));

  i_seq_monitor #(.W(W), .INC_MAX(INC_MAX), .DEC_START(DEC_START), .CNT_W(4), .TIMEOUT(TMO)) dut4 (
    .CLK(CLK), .RST(RST), .CE(CE), .inc(inc), .dec(dec), .phase(phase4),
    .cycles(cycles4), .done(done4), .err(err4), .err_code(err_code4));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  int m_phase, m_cyc, m_done, m_err, m_code, m_pinc, m_pdec, m_stall;

  bit track;
  int done_seen;
  int ph_hist[$];

  typedef struct {
    bit rst;
    int i;
    int d;
    int ph;
    int er;
    int code;
    int dn;
    int cyc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // expected loop: index p -> (inc,dec)
  function automatic void loop_val(input int p, output int vi, output int vd);
    if (p <= INC_MAX) begin
      vi = p;
      vd = 0;
    end else begin
      vi = INC_MAX;
      vd = DEC_START - (p - INC_MAX - 1);
    end
  endfunction

  // reference: list the legal successors of the previous sample and test membership
  task automatic model_step();
    int ci, cd, to;
    bit matched;
    int s_i[$], s_d[$], s_p[$];
    ci = int'(inc);
    cd = int'(dec);
    if (RST) begin
      m_phase = 0; m_cyc = 0; m_done = 0; m_err = 0; m_code = 0;
      m_pinc = 0; m_pdec = 0; m_stall = 0;
    end else begin
      m_done = 0;
      matched = 0;
      to = 0;
      if (m_phase == 0) begin
        if (ci == 0 && cd == 0) begin
          m_phase = 1;
          m_stall = 0;
        end
      end else if (m_phase == 1 || m_phase == 2) begin
        if (m_phase == 1) begin
          if (m_pinc < INC_MAX) begin
            s_i.push_back(m_pinc + 1); s_d.push_back(0); s_p.push_back(1);
          end
          if (m_pinc == INC_MAX && m_pdec == 0) begin
            s_i.push_back(INC_MAX); s_d.push_back(DEC_START); s_p.push_back(2);
          end
        end else begin
          if (m_pdec > 0) begin
            s_i.push_back(INC_MAX); s_d.push_back(m_pdec - 1); s_p.push_back(2);
          end
          if (m_pdec == 0 && m_pinc == INC_MAX) begin
            s_i.push_back(0); s_d.push_back(0); s_p.push_back(1);
          end
        end
        if (ci == m_pinc && cd == m_pdec) begin
`ifdef SEQ_MON_STALL_EN
          if (CE) m_stall++;
          if (m_stall == TMO) begin
            m_phase = 3; m_err = 1; m_code = 3;
          end
`endif
        end else begin
          foreach (s_i[k])
            if (s_i[k] == ci && s_d[k] == cd) begin
              matched = 1;
              to = s_p[k];
            end
          if (matched) begin
            if (m_phase == 2 && to == 1) begin
              m_done = 1;
              m_cyc++;
            end
            m_phase = to;
            m_stall = 0;
          end else begin
            m_phase = 3;
            m_err = 1;
            m_code = (ci != m_pinc) ? 1 : 2;
          end
        end
      end
      m_pinc = ci;
      m_pdec = cd;
    end
  endtask

  task automatic check_all();
    chk("phase", int'(phase), m_phase);
    chk("err", int'(err), m_err);
    chk("err_code", int'(err_code), m_code);
    chk("done", int'(done), m_done);
    chk("cycles", int'(cycles), m_cyc % 65536);
    chk("phase4", int'(phase4), m_phase);
    chk("cycles4", int'(cycles4), m_cyc % 16);
    chk("done4", int'(done4), m_done);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
    if (track) begin
      if (done) done_seen++;
      if (int'(phase) != ph_hist[$]) ph_hist.push_back(int'(phase));
    end
  endtask

  task automatic drive(input bit r, input bit c, input int i, input int d);
    RST = r;
    CE  = c;
    inc = W'(i);
    dec = W'(d);
    tick();
  endtask

  // behavioural counter: each value held per cycles, CE on the last one
  task automatic run_loops(input int n, input int per);
    int vi, vd;
    for (int l = 0; l < n; l++)
      for (int p = 0; p < L; p++) begin
        loop_val(p, vi, vd);
        for (int k = 0; k < per; k++) drive(0, (k == per - 1), vi, vd);
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vi, vd, pos, r;
    int exp_hist[$];
    RST = 1'b1; CE = 1'b0; inc = '0; dec = '0;
    m_phase = 0; m_cyc = 0; m_done = 0; m_err = 0; m_code = 0;
    m_pinc = 0; m_pdec = 0; m_stall = 0;
    track = 0; done_seen = 0;

    // ---- vector table: rst, inc, dec -> phase, err, code, done, cycles
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 3, 7, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 4, 0, 3, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 3, 1, 1, 0, 0});
    tbl.push_back('{0, 5, 5, 3, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
    for (int i = 1; i <= 6; i++) tbl.push_back('{0, i, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 3, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 1, 3, 1, 2, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
    for (int i = 1; i <= 6; i++) tbl.push_back('{0, i, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 3, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 2, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 0, 2, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1});
    for (int i = 1; i <= 6; i++) tbl.push_back('{0, i, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 5, 3, 3, 1, 1, 0, 1});
    tbl.push_back('{0, 6, 3, 3, 1, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0});

    foreach (tbl[n]) begin
      drive(tbl[n].rst, 1'b0, tbl[n].i, tbl[n].d);
      chk($sformatf("tbl[%0d].phase", n), int'(phase), tbl[n].ph);
      chk($sformatf("tbl[%0d].err", n), int'(err), tbl[n].er);
      chk($sformatf("tbl[%0d].err_code", n), int'(err_code), tbl[n].code);
      chk($sformatf("tbl[%0d].done", n), int'(done), tbl[n].dn);
      chk($sformatf("tbl[%0d].cycles", n), int'(cycles), tbl[n].cyc);
    end

    // ---- two nominal loops, CE 1-in-4
    drive(1, 0, 0, 0);
    ph_hist.delete();
    ph_hist.push_back(int'(phase));
    done_seen = 0;
    track = 1;
    run_loops(2, 4);
    drive(0, 0, 0, 0);
    track = 0;
    exp_hist = '{0, 1, 2, 1, 2, 1};
    chk("nominal.cycles", int'(cycles), 2);
    chk("nominal.done_pulses", done_seen, 2);
    chk("nominal.err", int'(err), 0);
    chk("nominal.phase_steps", ph_hist.size(), exp_hist.size());
    foreach (exp_hist[k])
      if (k < ph_hist.size()) chk($sformatf("nominal.phase_seq[%0d]", k), ph_hist[k], exp_hist[k]);

    // ---- stall behaviour
    drive(1, 0, 0, 0);
    for (int i = 0; i <= 3; i++) drive(0, 0, i, 0);
`ifdef SEQ_MON_STALL_EN
    for (int k = 0; k < TMO - 1; k++) drive(0, 1, 3, 0);
    chk("stall.before_change.err", int'(err), 0);
    drive(0, 0, 4, 0);
    chk("stall.after_change.err", int'(err), 0);
    for (int k = 0; k < TMO - 1; k++) begin
      drive(0, 1, 4, 0);
      drive(0, 0, 4, 0);
    end
    chk("stall.seven_ticks.err", int'(err), 0);
    drive(0, 1, 4, 0);
    chk("stall.trip.err", int'(err), 1);
    chk("stall.trip.code", int'(err_code), 3);
    chk("stall.trip.phase", int'(phase), 3);
`else
    for (int k = 0; k < 1000; k++) drive(0, 1, 3, 0);
    chk("nostall.err", int'(err), 0);
    chk("nostall.phase", int'(phase), 1);
`endif

    // ---- reset while falling with cycles=5, then restart
    drive(1, 0, 0, 0);
    run_loops(5, 2);
    for (int p = 0; p <= INC_MAX + 2; p++) begin
      loop_val(p, vi, vd);
      drive(0, 0, vi, vd);
    end
    chk("midreset.pre.cycles", int'(cycles), 5);
    chk("midreset.pre.phase", int'(phase), 2);
    drive(1, 0, 6, 2);
    chk("midreset.phase", int'(phase), 0);
    chk("midreset.cycles", int'(cycles), 0);
    chk("midreset.err", int'(err), 0);
    chk("midreset.done", int'(done), 0);
    run_loops(1, 3);
    drive(0, 0, 0, 0);
    chk("restart.cycles", int'(cycles), 1);
    chk("restart.err", int'(err), 0);

    // ---- 16 loops: 4-bit counter wraps to 0
    drive(1, 0, 0, 0);
    done_seen = 0;
    ph_hist.delete();
    ph_hist.push_back(int'(phase));
    track = 1;
    run_loops(16, 1);
    drive(0, 0, 0, 0);
    track = 0;
    chk("wrap.cycles4", int'(cycles4), 0);
    chk("wrap.cycles16", int'(cycles), 16);
    chk("wrap.done_pulses", done_seen, 16);
    chk("wrap.err4", int'(err4), 0);

    // ---- randomized walk with occasional corruption and reset
    drive(1, 0, 0, 0);
    pos = 0;
    for (int it = 0; it < 4000; it++) begin
      r = int'($urandom_range(0, 999));
      if (r >= 600) pos = (pos + 1) % L;
      loop_val(pos, vi, vd);
      if ($urandom_range(0, 999) < 5) begin
        vi = int'($urandom_range(0, 7));
        vd = int'($urandom_range(0, 7));
      end
      drive((r < 8), 1'($urandom_range(0, 1)), vi, vd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
